// File: rtl/vector_stream_regfile.sv
// Flop-based vector bank: 1-cycle parallel load, stream write (deserialise) and stream read (serialise).
// s_ready drops while a parallel load targets the vector being streamed; m_data holds under m_ready low.
module vector_stream_regfile #(
   parameter int SCALAR_BITS = 32,
   parameter int LENGTH      = 5,
   parameter int NUM_VECTORS = 4,
   localparam int INDEX_WIDTH = (LENGTH > 1) ? $clog2(LENGTH) : 1,
   localparam int SEL_WIDTH   = (NUM_VECTORS > 1) ? $clog2(NUM_VECTORS) : 1,
   localparam int SIZE_BITS   = LENGTH * SCALAR_BITS
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   load,
   input  logic [SEL_WIDTH-1:0]   load_sel,
   input  logic [SIZE_BITS-1:0]   in,
   input  logic [SEL_WIDTH-1:0]   out_sel,
   output logic [SIZE_BITS-1:0]   out,
   input  logic                   wr_start,
   input  logic [SEL_WIDTH-1:0]   wr_sel,
   input  logic                   s_valid,
   output logic                   s_ready,
   input  logic [SCALAR_BITS-1:0] s_data,
   output logic                   wr_done,
   input  logic                   rd_start,
   input  logic [SEL_WIDTH-1:0]   rd_sel,
   output logic                   m_valid,
   input  logic                   m_ready,
   output logic [SCALAR_BITS-1:0] m_data,
   output logic                   m_last,
   output logic                   wr_busy,
   output logic                   rd_busy
);

   localparam logic [INDEX_WIDTH-1:0] LAST_IDX = INDEX_WIDTH'(LENGTH - 1);

   typedef enum logic {W_IDLE, W_BUSY} wr_state_t;
   typedef enum logic {R_IDLE, R_BUSY} rd_state_t;

   logic [SIZE_BITS-1:0]   r_mem [NUM_VECTORS];
   wr_state_t              r_wr_state;
   wr_state_t              w_wr_state_nxt;
   logic [SEL_WIDTH-1:0]   r_wr_vec;
   logic [INDEX_WIDTH-1:0] r_wr_idx;
   logic                   r_wr_done;
   logic                   w_wr_fire;
   logic                   w_wr_last;
   rd_state_t              r_rd_state;
   rd_state_t              w_rd_state_nxt;
   logic [SEL_WIDTH-1:0]   r_rd_vec;
   logic [INDEX_WIDTH-1:0] r_rd_idx;
   logic                   w_rd_fire;
   int                     w_wr_lsb;
   int                     w_rd_lsb;

   assign w_wr_lsb = int'(r_wr_idx) * SCALAR_BITS;
   assign w_rd_lsb = int'(r_rd_idx) * SCALAR_BITS;
   assign out      = r_mem[out_sel];
   assign m_data   = r_mem[r_rd_vec][w_rd_lsb +: SCALAR_BITS];
   assign wr_done  = r_wr_done;

   // Load and stream write to the same vector never commit together: s_ready excludes that case.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int v = 0; v < NUM_VECTORS; v++) r_mem[v] <= '0;
      end else begin
         for (int v = 0; v < NUM_VECTORS; v++) begin
            if (load && load_sel == SEL_WIDTH'(v))
               r_mem[v] <= in;
            else if (w_wr_fire && r_wr_vec == SEL_WIDTH'(v))
               r_mem[v][w_wr_lsb +: SCALAR_BITS] <= s_data;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_state <= W_IDLE;
         r_wr_vec   <= '0;
         r_wr_idx   <= '0;
         r_wr_done  <= 1'b0;
      end else begin
         r_wr_state <= w_wr_state_nxt;
         r_wr_done  <= w_wr_last;
         if (r_wr_state == W_IDLE && wr_start) begin
            r_wr_vec <= wr_sel;
            r_wr_idx <= '0;
         end else if (w_wr_fire) begin
            r_wr_idx <= w_wr_last ? '0 : r_wr_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_wr_state_nxt = r_wr_state;
      s_ready        = 1'b0;
      wr_busy        = 1'b0;
      w_wr_fire      = 1'b0;
      w_wr_last      = 1'b0;
      case (r_wr_state)
         W_IDLE: if (wr_start) w_wr_state_nxt = W_BUSY;
         W_BUSY: begin
            wr_busy   = 1'b1;
            s_ready   = !(load && load_sel == r_wr_vec);
            w_wr_fire = s_valid && !(load && load_sel == r_wr_vec);
            w_wr_last = w_wr_fire && (r_wr_idx == LAST_IDX);
            if (w_wr_last) w_wr_state_nxt = W_IDLE;
         end
         default: w_wr_state_nxt = W_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_rd_state <= R_IDLE;
         r_rd_vec   <= '0;
         r_rd_idx   <= '0;
      end else begin
         r_rd_state <= w_rd_state_nxt;
         if (r_rd_state == R_IDLE && rd_start) begin
            r_rd_vec <= rd_sel;
            r_rd_idx <= '0;
         end else if (w_rd_fire) begin
            r_rd_idx <= m_last ? '0 : r_rd_idx + 1'b1;
         end
      end
   end

   always_comb begin
      w_rd_state_nxt = r_rd_state;
      m_valid        = 1'b0;
      m_last         = 1'b0;
      rd_busy        = 1'b0;
      w_rd_fire      = 1'b0;
      case (r_rd_state)
         R_IDLE: if (rd_start) w_rd_state_nxt = R_BUSY;
         R_BUSY: begin
            rd_busy   = 1'b1;
            m_valid   = 1'b1;
            m_last    = (r_rd_idx == LAST_IDX);
            w_rd_fire = m_ready;
            if (m_ready && r_rd_idx == LAST_IDX) w_rd_state_nxt = R_IDLE;
         end
         default: w_rd_state_nxt = R_IDLE;
      endcase
   end

endmodule

// File: doc/vector_stream_regfile.md
# vector_stream_regfile

Bank of `NUM_VECTORS` vector registers, each `LENGTH` scalars of `SCALAR_BITS`. It supports full-vector parallel load and read, plus two independent streaming engines. The write engine deserialises a slice stream into a chosen vector; the read engine serialises a chosen vector into a slice stream with valid/ready handshakes. It sits between the sample/weight input streams and the parallel matrix-vector datapath of the LCMV classifier, replacing single-vector storage where several vectors must be filled and drained concurrently.

## Interface
- `SCALAR_BITS`, 32, bits per scalar
- `LENGTH`, 5, scalars per vector (≥1)
- `NUM_VECTORS`, 4, number of vectors (≥1)
- localparam `INDEX_WIDTH` = max(1, $clog2(LENGTH)); `SEL_WIDTH` = max(1, $clog2(NUM_VECTORS)); `SIZE_BITS` = LENGTH*SCALAR_BITS
- Clocking and reset (already decided): one clock; reset is asynchronous and active-low.
- `clk` in 1: sole clock, rising edge
- `rst_n` in 1: asynchronous active-low reset
- `load` in 1: parallel load of `in` into vector `load_sel`
- `load_sel` in SEL_WIDTH: target vector of parallel load
- `in` in SIZE_BITS: parallel load data, scalar i at bits [i*SCALAR_BITS +: SCALAR_BITS]
- `out_sel` in SEL_WIDTH: vector shown on `out`
- `out` out SIZE_BITS: combinational, current contents of vector `out_sel`
- `wr_start` in 1: start stream write (ignored unless write engine idle)
- `wr_sel` in SEL_WIDTH: target vector, captured on accepted `wr_start`
- `s_valid` in 1 / `s_ready` out 1 / `s_data` in SCALAR_BITS: input slice stream
- `wr_done` out 1: one-cycle pulse after last slice written
- `rd_start` in 1: start stream read (ignored unless read engine idle)
- `rd_sel` in SEL_WIDTH: source vector, captured on accepted `rd_start`
- `m_valid` out 1 / `m_ready` in 1 / `m_data` out SCALAR_BITS / `m_last` out 1: output slice stream
- `wr_busy`, `rd_busy` out 1: engine active

## Operation
- Storage: NUM_VECTORS×SIZE_BITS flops; no memory macro.
- Write engine FSM: W_IDLE → W_BUSY on `wr_start`. It captures `wr_sel` into `wr_vec` and clears `wr_idx`.
  - In W_BUSY, a beat is accepted when `s_valid && s_ready`. The beat writes `s_data` into scalar `wr_idx` of `wr_vec` and increments `wr_idx`.
  - Acceptance of beat `wr_idx == LENGTH-1` → W_IDLE, and `wr_done` = 1 next cycle.
- `s_ready` = W_BUSY && !(load && load_sel == wr_vec). Parallel load always wins. A colliding beat is stalled, not dropped.
- Read engine FSM: R_IDLE → R_BUSY on `rd_start`. It captures `rd_sel` into `rd_vec` and clears `rd_idx`.
  - `m_valid` = R_BUSY. `m_data` = scalar `rd_idx` of `rd_vec`, combinational from current storage. `m_last` = R_BUSY && `rd_idx == LENGTH-1`.
  - A handshake increments `rd_idx`. A handshake with `m_last` → R_IDLE.
- `m_data` stays stable while `m_valid && !m_ready`, unless the same scalar is rewritten that cycle. Writes become visible the cycle after they commit.
- Engines are independent and may target the same vector. The read then returns the old or new scalar according to commit order: no bypass, register value only.
- `load` to vectors other than `wr_vec` proceeds without affecting streams.

## Timing
- Reset (async assert, sync release): all vectors 0; both FSMs idle; `wr_idx` = `rd_idx` = 0; `s_ready`, `m_valid`, `m_last`, `wr_done`, `wr_busy`, `rd_busy` = 0.
- `wr_start` at cycle t → `s_ready` can be high at t+1. The earliest write completes in LENGTH cycles, and `wr_done` is at t+LENGTH+1.
- `rd_start` at t → first `m_valid` at t+1. With `m_ready` held high, LENGTH beats arrive in t+1..t+LENGTH and `m_valid` = 0 at t+LENGTH+1.
- `wr_start`/`rd_start` in the same cycle as that engine's final beat is ignored. A restart is accepted from the following cycle onward.
- `load` latency: 1 cycle to `out`.
- LENGTH = 1: the single beat is simultaneously first and last; `m_last` is high with every `m_valid`.
- Reset mid-stream aborts both engines. Partially written scalars are cleared by the reset.

## Test plan
- Reset then idle: `out` for every `out_sel` = 0; `s_ready` = `m_valid` = `wr_done` = 0. Check with SCALAR_BITS=8, LENGTH=5, NUM_VECTORS=4.
- Stream write vec 2 with slices 0x11..0x55, `s_valid` toggled every other cycle → `out_sel`=2 shows 0x5544332211; exactly one `wr_done` pulse; other vectors 0.
- Stream read vec 2 with `m_ready` stalled on beats 1 and 3 → `m_data` sequence 0x11,0x22,0x33,0x44,0x55, held stable during stalls; `m_last` only on 0x55.
- Collision: stream writing vec 1 while `load`=1, `load_sel`=1, `in`=0xAAAAAAAAAA → `s_ready` low that cycle and the beat is stalled. The final vec 1 has the loaded value overwritten only at scalars streamed afterwards.
- Concurrent: write vec 0 and read vec 3 started the same cycle with both streams at full rate → both finish in 5 beats, and vec 3 data is unchanged.
- `rd_start` pulsed while `rd_busy` → ignored, and the sequence is not restarted. Async reset asserted mid-read → `m_valid` = 0 immediately.
